// File: rtl/ddr_cmd_pkg.sv
// ---------------------------------------------------------------------------
// ddr_cmd_pkg
// Shared definitions for the DDR command path: executor FSM states, DDR
// controller user-interface command codes, command field widths and the
// packed layout of one 178-bit FIFO command entry. Also used by cmd_fifo.
// ---------------------------------------------------------------------------
package ddr_cmd_pkg;

  localparam int ADDR_W  = 27;
  localparam int BURST_W = 6;
  localparam int DATA_W  = 128;
  localparam int MASK_W  = 16;

  localparam logic [2:0] APP_CMD_WR  = 3'b000;
  localparam logic [2:0] APP_CMD_RD  = 3'b001;
  localparam logic       CMD_TYPE_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_LATCH   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_e;

  // One FIFO entry; field order matches the 178-bit FIFO word.
  typedef struct packed {
    logic               cmd_type;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burst_cnt;
    logic [DATA_W-1:0]  wt_data;
    logic [MASK_W-1:0]  wt_mask;
  } cmd_t;

  // Map the FIFO command type bit onto the controller command code.
  function automatic logic [2:0] app_cmd_of(input logic cmd_type);
    if (cmd_type == CMD_TYPE_WR) begin
      return APP_CMD_WR;
    end else begin
      return APP_CMD_RD;
    end
  endfunction

endpackage

// File: rtl/ddr_rd_collector.sv
// ---------------------------------------------------------------------------
// ddr_rd_collector
// Read-return path of the DDR command executor. While active it turns each
// controller read beat into a registered response beat one cycle later,
// counts beats to flag the last one, and aborts the read when no beat
// arrives for RD_TIMEOUT cycles (sticky error).
// Ports:
//   clk_i, rstn_i       clock, async active-low reset
//   start_i             clear beat and timeout counters (read command accepted)
//   active_i            executor is waiting for read beats
//   burst_cnt_i         beats minus 1 of the current read
//   rd_valid_i/data_i   controller read beat
//   rsp_valid_o/data_o/last_o  registered response beat
//   done_o              read finishes this cycle (last beat or timeout)
//   err_o               sticky read-timeout flag
// ---------------------------------------------------------------------------
module ddr_rd_collector
  import ddr_cmd_pkg::*;
#(
  parameter int RD_TIMEOUT = 1024,
  parameter int TO_W       = 10
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               active_i,
  input  logic [BURST_W-1:0] burst_cnt_i,
  input  logic               rd_valid_i,
  input  logic [DATA_W-1:0]  rd_data_i,
  output logic               rsp_valid_o,
  output logic [DATA_W-1:0]  rsp_data_o,
  output logic               rsp_last_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(RD_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  logic [6:0]        beat_q,      beat_d;
  logic [TO_W-1:0]   to_q,        to_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_last_q,  rsp_last_d;
  logic              err_q,       err_d;

  logic beat_s;
  logic last_s;
  logic timeout_s;

  // Beats outside the wait window are ignored, so late data never escapes.
  always_comb begin
    beat_s    = active_i && rd_valid_i;
    last_s    = beat_s && (beat_q == {1'b0, burst_cnt_i});
    timeout_s = active_i && !rd_valid_i && (to_q == TO_LIMIT);
    done_o    = last_s || timeout_s;
  end

  // Next-state for counters, response register and sticky error.
  always_comb begin
    beat_d      = beat_q;
    to_d        = to_q;
    rsp_valid_d = beat_s;
    rsp_last_d  = last_s;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q | timeout_s;
    if (start_i) begin
      beat_d = 7'd0;
      to_d   = {TO_W{1'b0}};
    end else if (beat_s) begin
      beat_d = beat_q + 7'd1;
      to_d   = {TO_W{1'b0}};
    end else if (active_i) begin
      to_d   = to_q + TO_ONE;
    end else begin
      to_d   = to_q;
    end
    if (beat_s) begin
      rsp_data_d = rd_data_i;
    end else begin
      rsp_data_d = rsp_data_q;
    end
  end

  // Collector state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      beat_q      <= 7'd0;
      to_q        <= {TO_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
      rsp_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      to_q        <= to_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;
  assign err_o       = err_q;

endmodule

// File: rtl/ddr_cmd_executor.sv
// ---------------------------------------------------------------------------
// ddr_cmd_executor
// Pop-side consumer of the DDR command FIFO in the controller user clock
// domain. Pops one command, latches it, issues it on the controller user
// interface (command channel plus one write beat) and, for reads, streams
// the returned beats out as responses. One command in flight at a time.
// Ports:
//   clk, rstn               user clock, async active-low reset
//   init_calib_complete     gates starting a new command
//   io_pop_*                FIFO read request and registered FIFO output
//   app_cmd_*, app_addr, app_burst_number   controller command channel
//   app_wdf_*               controller write-data channel
//   app_rd_data_valid/data  controller read return
//   io_rsp_*                response stream (always accepted)
//   busy                    FSM not idle
//   err_rd_timeout          sticky read timeout
// ---------------------------------------------------------------------------
module ddr_cmd_executor
  import ddr_cmd_pkg::*;
#(
  parameter int RD_TIMEOUT = 1024,
  parameter int TO_W       = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               init_calib_complete,
  output logic               io_pop_valid,
  input  logic               io_pop_ready,
  input  logic               io_pop_cmd_type,
  input  logic [ADDR_W-1:0]  io_pop_addr,
  input  logic [BURST_W-1:0] io_pop_burst_cnt,
  input  logic [DATA_W-1:0]  io_pop_wt_data,
  input  logic [MASK_W-1:0]  io_pop_wt_mask,
  output logic               app_cmd_en,
  output logic [2:0]         app_cmd,
  output logic [ADDR_W-1:0]  app_addr,
  output logic [BURST_W-1:0] app_burst_number,
  input  logic               app_cmd_rdy,
  output logic               app_wdf_wren,
  output logic [DATA_W-1:0]  app_wdf_data,
  output logic [MASK_W-1:0]  app_wdf_mask,
  output logic               app_wdf_end,
  input  logic               app_wdf_rdy,
  input  logic               app_rd_data_valid,
  input  logic [DATA_W-1:0]  app_rd_data,
  output logic               io_rsp_valid,
  output logic [DATA_W-1:0]  io_rsp_data,
  output logic               io_rsp_last,
  output logic               busy,
  output logic               err_rd_timeout
);

  state_e             state_q,     state_d;
  cmd_t               cmd_q,       cmd_d;
  logic               pop_valid_q, pop_valid_d;
  logic               cmd_en_q,    cmd_en_d;
  logic               wren_q,      wren_d;
  logic [2:0]         app_cmd_q,   app_cmd_d;
  logic [BURST_W-1:0] burst_num_q, burst_num_d;
  logic               busy_q;

  logic rd_start_s;
  logic rd_done_s;
  logic rd_active_s;

  assign rd_active_s = (state_q == ST_RD_WAIT);

  // Next-state and registered-output decisions of the command FSM.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    pop_valid_d = 1'b0;
    cmd_en_d    = cmd_en_q;
    wren_d      = wren_q;
    app_cmd_d   = app_cmd_q;
    burst_num_d = burst_num_q;
    rd_start_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Calibration only gates starting; a command in progress runs on.
        if (init_calib_complete && io_pop_ready) begin
          state_d     = ST_POP;
          pop_valid_d = 1'b1;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_POP: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // FIFO Q is valid now; load it and raise both channels for ISSUE.
        cmd_d.cmd_type  = io_pop_cmd_type;
        cmd_d.addr      = io_pop_addr;
        cmd_d.burst_cnt = io_pop_burst_cnt;
        cmd_d.wt_data   = io_pop_wt_data;
        cmd_d.wt_mask   = io_pop_wt_mask;
        app_cmd_d       = app_cmd_of(io_pop_cmd_type);
        if (io_pop_cmd_type == CMD_TYPE_WR) begin
          burst_num_d = {BURST_W{1'b0}};
          wren_d      = 1'b1;
        end else begin
          burst_num_d = io_pop_burst_cnt;
          wren_d      = 1'b0;
        end
        cmd_en_d = 1'b1;
        state_d  = ST_LATCH == state_q ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: begin
        // Each channel drops the cycle after its own handshake.
        if (cmd_en_q && app_cmd_rdy) begin
          cmd_en_d = 1'b0;
        end else begin
          cmd_en_d = cmd_en_q;
        end
        if (wren_q && app_wdf_rdy) begin
          wren_d = 1'b0;
        end else begin
          wren_d = wren_q;
        end
        if (cmd_q.cmd_type == CMD_TYPE_WR) begin
          if (!cmd_en_d && !wren_d) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          if (!cmd_en_d) begin
            state_d    = ST_RD_WAIT;
            rd_start_s = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_RD_WAIT: begin
        if (rd_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cmd_en_d = 1'b0;
        wren_d   = 1'b0;
      end
    endcase
  end

  // FSM state, latched command and registered interface outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      pop_valid_q <= 1'b0;
      cmd_en_q    <= 1'b0;
      wren_q      <= 1'b0;
      app_cmd_q   <= 3'b000;
      burst_num_q <= {BURST_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pop_valid_q <= pop_valid_d;
      cmd_en_q    <= cmd_en_d;
      wren_q      <= wren_d;
      app_cmd_q   <= app_cmd_d;
      burst_num_q <= burst_num_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  ddr_rd_collector #(
    .RD_TIMEOUT (RD_TIMEOUT),
    .TO_W       (TO_W)
  ) u_rd_collector (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (rd_start_s),
    .active_i    (rd_active_s),
    .burst_cnt_i (cmd_q.burst_cnt),
    .rd_valid_i  (app_rd_data_valid),
    .rd_data_i   (app_rd_data),
    .rsp_valid_o (io_rsp_valid),
    .rsp_data_o  (io_rsp_data),
    .rsp_last_o  (io_rsp_last),
    .done_o      (rd_done_s),
    .err_o       (err_rd_timeout)
  );

  assign io_pop_valid     = pop_valid_q;
  assign app_cmd_en       = cmd_en_q;
  assign app_cmd          = app_cmd_q;
  assign app_addr         = cmd_q.addr;
  assign app_burst_number = burst_num_q;
  assign app_wdf_wren     = wren_q;
  assign app_wdf_end      = wren_q;
  assign app_wdf_data     = cmd_q.wt_data;
  assign app_wdf_mask     = cmd_q.wt_mask;
  assign busy             = busy_q;

endmodule
